fp_norm_round_pipe: RTL and testbench

FP_NORM_ROUND_PIPE -- requirements
Module: fp_norm_round_pipe

---
 rtl/fp_invsqrt_pkg.sv | 13 +
 rtl/fp_round_inc.sv | 27 ++
 rtl/fp_norm_round_pipe.sv | 138 +++++++++++++
 tb/tb_fp_norm_round_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_invsqrt_pkg.sv
// Shared constants for the floating-point normalise/round datapath.
//   RND_*             : rounding-mode encodings seen on rnd_mode
//   EXP_BASE_DEFAULT  : exponent emitted when the mantissa does not overflow
package fp_invsqrt_pkg;

  localparam logic [1:0] RND_TRUNC      = 2'b00;
  localparam logic [1:0] RND_HALF_UP    = 2'b01;
  localparam logic [1:0] RND_NEAR_EVEN  = 2'b10;
  localparam logic [1:0] RND_TRUNC_ALT  = 2'b11;

  localparam logic [7:0] EXP_BASE_DEFAULT = 8'h7E;

endpackage

// File: rtl/fp_round_inc.sv
// Rounding increment decision.
//   mode_i   : rounding mode (truncate / half-up / nearest-even / truncate)
//   lsb_i    : LSB of the kept mantissa
//   guard_i  : first bit below the kept mantissa
//   sticky_i : OR of all bits below the guard bit
//   inc_o    : 1 when the kept mantissa must be incremented
module fp_round_inc
  import fp_invsqrt_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  output logic       inc_o
);

  always_comb begin
    inc_o = 1'b0;
    case (mode_i)
      RND_HALF_UP:   inc_o = guard_i;
      // Ties go to the even neighbour: only an odd LSB breaks an exact tie upwards.
      RND_NEAR_EVEN: inc_o = guard_i & (sticky_i | lsb_i);
      default:       inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise-and-round pipeline with valid/ready flow control.
//   clk, rst         : clock, asynchronous active-high reset
//   valid / in_ready : input handshake (transfer when both are 1)
//   M_sub            : unnormalised mantissa, MSB is the overflow bit
//   float_in_delay   : sideband travelling with each item
//   error_in         : upstream error flag
//   rnd_mode         : rounding mode
//   backprn          : downstream accepts the output this cycle
//   float_out        : {exponent, mantissa}
//   float_out_delay  : sideband aligned to float_out
//   ready            : float_out holds a valid item
//   error_out        : error_in OR underflow, aligned to float_out
module fp_norm_round_pipe
  import fp_invsqrt_pkg::*;
#(
  parameter int unsigned    MW       = 23,
  parameter int unsigned    RW       = 3,
  parameter int unsigned    EW       = 8,
  parameter int unsigned    DW       = 31,
  parameter logic [EW-1:0]  EXP_BASE = EW'(EXP_BASE_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  output logic               in_ready,
  input  logic [MW+RW:0]     M_sub,
  input  logic [DW-1:0]      float_in_delay,
  input  logic               error_in,
  input  logic [1:0]         rnd_mode,
  input  logic               backprn,
  output logic [EW+MW-1:0]   float_out,
  output logic [DW-1:0]      float_out_delay,
  output logic               ready,
  output logic               error_out
);

  localparam int unsigned SW = MW + RW + 1;

  // Flow control: a stage loads when empty or when its contents move on.
  logic s2_load_c;
  logic s1_load_c;

  // Stage 1 contents
  logic              s1_valid_q;
  logic [MW-1:0]     s1_mant_q;
  logic              s1_guard_q;
  logic              s1_sticky_q;
  logic              s1_ov_q;
  logic [1:0]        s1_mode_q;
  logic [DW-1:0]     s1_delay_q;
  logic              s1_err_q;

  // Stage 2 contents
  logic              s2_valid_q;
  logic [EW+MW-1:0]  s2_float_q;
  logic [DW-1:0]     s2_delay_q;
  logic              s2_err_q;

  // Normalisation of the incoming mantissa (overflow bit dropped after the decision).
  logic              ov_c;
  logic [MW+RW-1:0]  m_ov_c;
  logic              underflow_c;

  assign ov_c        = M_sub[SW-1];
  assign m_ov_c      = ov_c ? M_sub[MW+RW-1:0] : {M_sub[MW+RW-2:0], 1'b0};
  assign underflow_c = ~|M_sub[SW-1:SW-2];

  assign s2_load_c = ~s2_valid_q | backprn;
  assign s1_load_c = ~s1_valid_q | s2_load_c;
  assign in_ready  = s1_load_c;

  // Stage 1 register: normalised mantissa, guard/sticky, ov, mode, sideband.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_ov_q     <= 1'b0;
      s1_mode_q   <= '0;
      s1_delay_q  <= '0;
      s1_err_q    <= 1'b0;
    end else if (s1_load_c) begin
      s1_valid_q <= valid;
      if (valid) begin
        s1_mant_q   <= m_ov_c[MW+RW-1:RW];
        s1_guard_q  <= m_ov_c[RW-1];
        s1_sticky_q <= |m_ov_c[RW-2:0];
        s1_ov_q     <= ov_c;
        s1_mode_q   <= rnd_mode;
        s1_delay_q  <= float_in_delay;
        s1_err_q    <= error_in | underflow_c;
      end
    end
  end

  // Rounding and result assembly between the stages.
  logic             inc_c;
  logic [MW:0]      sum_c;
  logic [EW-1:0]    exp_c;
  logic [EW+MW-1:0] s2_float_d;

  fp_round_inc u_round_inc (
    .mode_i   (s1_mode_q),
    .lsb_i    (s1_mant_q[0]),
    .guard_i  (s1_guard_q),
    .sticky_i (s1_sticky_q),
    .inc_o    (inc_c)
  );

  // A carry-out leaves the mantissa at zero and bumps the exponent.
  assign sum_c      = {1'b0, s1_mant_q} + (MW+1)'(inc_c);
  assign exp_c      = EXP_BASE + EW'(s1_ov_q) + EW'(sum_c[MW]);
  assign s2_float_d = {exp_c, sum_c[MW-1:0]};

  // Stage 2 register: rounded result plus aligned sideband and error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_float_q <= '0;
      s2_delay_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_load_c) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_float_q <= s2_float_d;
        s2_delay_q <= s1_delay_q;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  assign float_out       = s2_float_q;
  assign float_out_delay = s2_delay_q;
  assign ready           = s2_valid_q;
  assign error_out       = s2_valid_q & s2_err_q;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Self-checking bench for fp_norm_round_pipe (MW=23, RW=3, EW=8, DW=31).
module tb_fp_norm_round_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        in_ready;
  logic [26:0] M_sub = '0;
  logic [30:0] float_in_delay = '0;
  logic        error_in = 1'b0;
  logic [1:0]  rnd_mode = '0;
  logic        backprn = 1'b1;
  logic [30:0] float_out;
  logic [30:0] float_out_delay;
  logic        ready;
  logic        error_out;

  fp_norm_round_pipe dut (
    .clk             (clk),
    .rst             (rst),
    .valid           (valid),
    .in_ready        (in_ready),
    .M_sub           (M_sub),
    .float_in_delay  (float_in_delay),
    .error_in        (error_in),
    .rnd_mode        (rnd_mode),
    .backprn         (backprn),
    .float_out       (float_out),
    .float_out_delay (float_out_delay),
    .ready           (ready),
    .error_out       (error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] f;
    logic [30:0] d;
    logic        e;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad = 0;
  int    out_count = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: value = mantissa scaled so the leading one sits at bit 26,
  // then split into 23 kept bits and a 3-bit remainder compared against a half.
  function automatic item_t model(input logic [26:0] m, input logic [1:0] md,
                                  input logic e, input logic [30:0] d);
    item_t       it;
    int unsigned scaled, top, rem, inc, r, ex;
    logic        ovb;
    ovb    = m[26];
    scaled = ovb ? 32'(m) : ((32'(m) << 1) & 32'h07FF_FFFF);
    top    = (scaled >> 3) & 32'h007F_FFFF;
    rem    = scaled & 32'd7;
    inc    = 32'd0;
    if (md == 2'd1)
      inc = (rem >= 32'd4) ? 32'd1 : 32'd0;
    else if (md == 2'd2)
      inc = (rem > 32'd4 || (rem == 32'd4 && (top % 2) == 32'd1)) ? 32'd1 : 32'd0;
    r    = top + inc;
    ex   = 32'h7E + 32'(ovb) + (r >> 23);
    it.f = {ex[7:0], r[22:0]};
    it.d = d;
    it.e = e || (m < 27'h200_0000);
    return it;
  endfunction

  // Scoreboard: record input transfers, check every output transfer in order.
  always @(negedge clk) begin
    item_t ex;
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() == 0) begin
        chk("idle_ready", 64'(ready), 64'd0);
      end else if (ready && backprn) begin
        ex = q.pop_front();
        chk("out_data", 64'(float_out), 64'(ex.f));
        chk("out_side", 64'(float_out_delay), 64'(ex.d));
        chk("out_err", 64'(error_out), 64'(ex.e));
        out_count++;
      end
      if (valid && in_ready)
        q.push_back(model(M_sub, rnd_mode, error_in, float_in_delay));
    end
  end

  // Single item into an idle pipeline; result checked exactly 2 cycles later.
  task automatic send_check(input string nm, input logic [26:0] m, input logic [1:0] md,
                            input logic e, input logic [30:0] exp_f, input logic exp_e);
    logic [30:0] dly;
    item_t       mi;
    dly            = 31'($urandom);
    valid          = 1'b1;
    M_sub          = m;
    rnd_mode       = md;
    error_in       = e;
    float_in_delay = dly;
    backprn        = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_ready"}, 64'(ready), 64'd1);
    chk({nm, "_data"}, 64'(float_out), 64'(exp_f));
    chk({nm, "_err"}, 64'(error_out), 64'(exp_e));
    chk({nm, "_side"}, 64'(float_out_delay), 64'(dly));
    mi = model(m, md, e, dly);
    chk({nm, "_model"}, 64'(mi.f), 64'(exp_f));
    @(posedge clk); #1;
  endtask

  logic [26:0] rm;
  int          sent;
  int          first_block;
  int          cyc;
  int          base;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_err", 64'(error_out), 64'd0);
    chk("rst_float", 64'(float_out), 64'd0);
    chk("rst_side", 64'(float_out_delay), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Literal pins
    send_check("one",      27'h400_0000, 2'd0, 1'b0, 31'h3F80_0000, 1'b0);
    send_check("half",     27'h200_0000, 2'd0, 1'b0, 31'h3F00_0000, 1'b0);
    send_check("carry_hu", 27'h7FF_FFFC, 2'd1, 1'b0, 31'h4000_0000, 1'b0);
    send_check("all1_tr",  27'h7FF_FFFC, 2'd0, 1'b0, 31'h3FFF_FFFF, 1'b0);
    send_check("all1_t3",  27'h7FF_FFFC, 2'd3, 1'b0, 31'h3FFF_FFFF, 1'b0);
    send_check("tie_ne",   27'h400_0004, 2'd2, 1'b0, 31'h3F80_0000, 1'b0);
    send_check("tie_hu",   27'h400_0004, 2'd1, 1'b0, 31'h3F80_0001, 1'b0);
    send_check("tie_odd",  27'h400_000C, 2'd2, 1'b0, 31'h3F80_0002, 1'b0);
    send_check("below_hu", 27'h400_0003, 2'd1, 1'b0, 31'h3F80_0000, 1'b0);
    send_check("uflow",    27'h100_0000, 2'd0, 1'b0, 31'h3F40_0000, 1'b1);
    send_check("err_in",   27'h400_0000, 2'd0, 1'b1, 31'h3F80_0000, 1'b1);

    // Backpressure: 5 items, backprn low for 4 cycles
    base        = out_count;
    sent        = 0;
    first_block = -1;
    cyc         = 0;
    fork
      begin
        backprn = 1'b0;
        repeat (4) @(posedge clk);
        #1 backprn = 1'b1;
      end
      begin
        while (sent < 5 && cyc < 50) begin
          valid          = 1'b1;
          M_sub          = 27'h400_0000 | 27'(sent * 8);
          rnd_mode       = 2'd0;
          error_in       = 1'b0;
          float_in_delay = 31'(100 + sent);
          @(negedge clk);
          if (in_ready) sent++;
          else if (first_block < 0) first_block = sent;
          @(posedge clk); #1;
          cyc++;
        end
        valid = 1'b0;
      end
    join
    chk("bp_sent", 64'(sent), 64'd5);
    chk("bp_inready_fall", 64'(first_block), 64'd2);
    cyc = 0;
    while (out_count - base < 5 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_all_out", 64'(out_count - base), 64'd5);

    // Reset with two items in flight
    valid    = 1'b1;
    M_sub    = 27'h400_0000;
    rnd_mode = 2'd0;
    @(posedge clk); #1;
    M_sub = 27'h500_0000;
    @(posedge clk); #1;
    valid   = 1'b0;
    backprn = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_err", 64'(error_out), 64'd0);
    chk("midrst_float", 64'(float_out), 64'd0);
    chk("midrst_side", 64'(float_out_delay), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    backprn = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("midrst_no_emit", 64'(ready), 64'd0);
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      rm = 27'($urandom);
      case ($urandom_range(0, 5))
        0: rm[26] = 1'b1;
        1: rm[26:25] = 2'b00;
        2: rm[26:25] = 2'b01;
        3: rm = 27'h7FF_FFF8 | 27'($urandom_range(0, 7));
        4: rm = 27'h3FF_FFFC | 27'($urandom_range(0, 3));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) rm[2:0] = 3'b100;
      valid          = ($urandom_range(0, 3) != 0);
      M_sub          = rm;
      rnd_mode       = 2'($urandom);
      error_in       = ($urandom_range(0, 7) == 0);
      float_in_delay = 31'($urandom);
      backprn        = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    valid   = 1'b0;
    backprn = 1'b1;
    cyc     = 0;
    while (q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
